// File: rtl/display_scan_ctrl.sv
// Scan controller for a bank of multiplexed common-anode 7-segment digits.
// Double-buffered nibble word, guard time, blanking, zero suppression.
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask_in,
    input  logic                    zero_suppress,
    output logic [3:0]              num,
    output logic                    seg_blank,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [0:0] GUARD = 1'b0;
    localparam logic [0:0] SHOW  = 1'b1;

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_GEND = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           idx, idx_n;
    logic [0:0]              state, state_n;
    logic [4*NUM_DIGITS-1:0] active, active_n;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   mask, mask_n;
    logic [NUM_DIGITS-1:0]   shadow_mask;
    logic                    pending_n;
    logic                    slot_wrap, frame_wrap;

    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   hz;
    logic                    dark_n;
    logic [3:0]              num_n;
    logic                    seg_blank_n;
    logic [NUM_DIGITS-1:0]   dig_en_n;

    // Next slot position, FSM state and buffer contents for this edge
    always_comb begin
        slot_wrap  = (cnt == CNT_LAST);
        frame_wrap = slot_wrap && (idx == IDX_LAST);
        cnt_n      = slot_wrap ? '0 : cnt + 1'b1;
        idx_n      = idx;
        if (slot_wrap)
            idx_n = (idx == IDX_LAST) ? '0 : idx + 1'b1;

        state_n = state;
        if (state == GUARD && cnt == CNT_GEND)
            state_n = SHOW;
        else if (state == SHOW && slot_wrap)
            state_n = GUARD;

        active_n  = active;
        mask_n    = mask;
        pending_n = pending;
        if (load)
            pending_n = 1'b1;
        if (frame_wrap) begin
            pending_n = 1'b0;
            if (load) begin
                active_n = data_in;
                mask_n   = blank_mask_in;
            end else if (pending) begin
                active_n = shadow;
                mask_n   = shadow_mask;
            end
        end
    end

    // Output values the registers take on this edge, from the next slot state
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++)
            nib[i] = active_n[4*i +: 4];
        hz = '0;
        hz[NUM_DIGITS-1] = (nib[NUM_DIGITS-1] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            hz[i] = hz[i+1] && (nib[i] == 4'h0);

        dark_n = mask_n[idx_n]
               || (zero_suppress && idx_n != '0 && hz[idx_n]);
        num_n       = nib[idx_n];
        seg_blank_n = (state_n == GUARD) || dark_n;
        dig_en_n    = '1;
        if (state_n == SHOW && !dark_n)
            dig_en_n[idx_n] = 1'b0;
    end

    // Scan state, buffers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            state       <= GUARD;
            active      <= '0;
            shadow      <= '0;
            mask        <= '0;
            shadow_mask <= '0;
            pending     <= 1'b0;
            num         <= 4'h0;
            seg_blank   <= 1'b1;
            dig_en      <= '1;
            frame_done  <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            idx        <= idx_n;
            state      <= state_n;
            active     <= active_n;
            mask       <= mask_n;
            pending    <= pending_n;
            if (load) begin
                shadow      <= data_in;
                shadow_mask <= blank_mask_in;
            end
            num        <= num_n;
            seg_blank  <= seg_blank_n;
            dig_en     <= dig_en_n;
            frame_done <= frame_wrap;
        end
    end

endmodule
